// File: rtl/fpmul_stage3_pack.sv
// -----------------------------------------------------------------------------
// fpmul_stage3_pack
//
// Final stage of a single-precision floating-point multiplier. Takes the raw
// exponent sum and the upper product bits from stage 2, then normalizes,
// rounds (nearest-even), saturates or flushes, and packs an IEEE-754 single.
//
// Pipeline:
//   p1 (stage A) : normalize + round, captured on the first edge
//   p2 (output)  : overflow/underflow/special-case packing into FP_Z
//   Latency is 2 edges and throughput is 1 per cycle. There is no backpressure.
//
// Ports:
//   clk              in   1   rising-edge clock
//   rst_n            in   1   asynchronous active-low reset
//   valid_stage2     in   1   stage-2 outputs valid this cycle
//   EXP_in           in   8   biased exponent sum (A+B-127 mod 256)
//   EXP_pos_stage2   in   1   both operand exponents >= 128 (overflow possible)
//   EXP_neg_stage2   in   1   both operand exponents < 127 (underflow possible)
//   SIG_in           in  28   product bits [47:20], leading one at 27 or 26
//   SIGN_out_stage2  in   1   result sign
//   isINF_stage2     in   1   result is infinity
//   isNaN_stage2     in   1   result is NaN
//   isZ_tab_stage2   in   1   result is zero
//   FP_Z             out 32   packed IEEE-754 single result
//   valid_out        out  1   FP_Z updated this cycle
//   FLAGS            out  3   {overflow, underflow, inexact}
//                             (only with FPMUL_STAGE3_FLAGS_EN)
//
// Configuration macro: FPMUL_STAGE3_FLAGS_EN adds the FLAGS output.
// -----------------------------------------------------------------------------
module fpmul_stage3_pack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_stage2,
  input  logic [7:0]  EXP_in,
  input  logic        EXP_pos_stage2,
  input  logic        EXP_neg_stage2,
  input  logic [27:0] SIG_in,
  input  logic        SIGN_out_stage2,
  input  logic        isINF_stage2,
  input  logic        isNaN_stage2,
  input  logic        isZ_tab_stage2,
  output logic [31:0] FP_Z,
  output logic        valid_out
`ifdef FPMUL_STAGE3_FLAGS_EN
  ,
  output logic [2:0]  FLAGS
`endif
);

  // The 8-bit exponent sum wraps mod 256. The pos/neg hints from stage 2
  // tell us which way it wrapped, so we can recover the true signed value.
  function automatic logic signed [9:0] f_ext_exp(
    input logic [7:0] exp8,
    input logic       pos,
    input logic       neg
  );
    logic signed [9:0] e;
    e = $signed({2'b00, exp8});
    if (pos && !exp8[7])
      e = e + 10'sd256;
    else if (neg && exp8[7])
      e = e - 10'sd256;
    return e;
  endfunction

  // Round to nearest, ties to even. Bit 23 of the result is the mantissa
  // carry-out. When it is set, the low 23 bits are already zero.
  function automatic logic [23:0] f_round(
    input logic [22:0] mant,
    input logic        guard,
    input logic        sticky
  );
    logic inc;
    inc = guard & (sticky | mant[0]);
    return {1'b0, mant} + {23'd0, inc};
  endfunction

  // Saturate to infinity or flush to zero. Subnormals are not produced.
  function automatic logic [31:0] f_sat_pack(
    input logic              sign,
    input logic signed [9:0] e,
    input logic [22:0]       mant
  );
    logic [31:0] z;
    if (e >= 10'sd255)
      z = {sign, 8'hFF, 23'h0};
    else if (e <= 10'sd0)
      z = {sign, 31'h0};
    else
      z = {sign, e[7:0], mant};
    return z;
  endfunction

  // Special cases take priority in this order: NaN, then infinity, then zero.
  function automatic logic [31:0] f_final(
    input logic              nan,
    input logic              inf,
    input logic              zero,
    input logic              sign,
    input logic signed [9:0] e,
    input logic [22:0]       mant
  );
    logic [31:0] z;
    if (nan)
      z = 32'h7FC0_0000;
    else if (inf)
      z = {sign, 8'hFF, 23'h0};
    else if (zero)
      z = {sign, 31'h0};
    else
      z = f_sat_pack(sign, e, mant);
    return z;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p0 -> p1: normalize and round (combinational from stage-2 inputs)
  // ---------------------------------------------------------------------------
  logic signed [9:0] w_exp_ext_p0;
  logic signed [9:0] w_exp_norm_p0;
  logic signed [9:0] w_exp_rnd_p0;
  logic [22:0]       w_mant_p0;
  logic              w_guard_p0;
  logic              w_sticky_p0;
  logic [23:0]       w_rnd_p0;

  always_comb begin
    w_exp_ext_p0 = f_ext_exp(EXP_in, EXP_pos_stage2, EXP_neg_stage2);
    // The product is either 1x.xxx or 01.xxx. A leading one at bit 27 means
    // the significand is shifted one place right, which bumps the exponent.
    if (SIG_in[27]) begin
      w_mant_p0     = SIG_in[26:4];
      w_guard_p0    = SIG_in[3];
      w_sticky_p0   = |SIG_in[2:0];
      w_exp_norm_p0 = w_exp_ext_p0 + 10'sd1;
    end else begin
      w_mant_p0     = SIG_in[25:3];
      w_guard_p0    = SIG_in[2];
      w_sticky_p0   = |SIG_in[1:0];
      w_exp_norm_p0 = w_exp_ext_p0;
    end
    w_rnd_p0     = f_round(w_mant_p0, w_guard_p0, w_sticky_p0);
    w_exp_rnd_p0 = w_rnd_p0[23] ? (w_exp_norm_p0 + 10'sd1) : w_exp_norm_p0;
  end

  logic              r_vld_p1;
  logic              r_sign_p1;
  logic              r_nan_p1;
  logic              r_inf_p1;
  logic              r_zero_p1;
  logic signed [9:0] r_exp_p1;
  logic [22:0]       r_mant_p1;
`ifdef FPMUL_STAGE3_FLAGS_EN
  logic              r_inexact_p1;
`endif

  // The special-case flags travel with their data word. They are never
  // re-sampled from the live inputs at the output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1     <= 1'b0;
      r_sign_p1    <= 1'b0;
      r_nan_p1     <= 1'b0;
      r_inf_p1     <= 1'b0;
      r_zero_p1    <= 1'b0;
      r_exp_p1     <= '0;
      r_mant_p1    <= '0;
`ifdef FPMUL_STAGE3_FLAGS_EN
      r_inexact_p1 <= 1'b0;
`endif
    end else begin
      r_vld_p1 <= valid_stage2;
      if (valid_stage2) begin
        r_sign_p1    <= SIGN_out_stage2;
        r_nan_p1     <= isNaN_stage2;
        r_inf_p1     <= isINF_stage2;
        r_zero_p1    <= isZ_tab_stage2;
        r_exp_p1     <= w_exp_rnd_p0;
        r_mant_p1    <= w_rnd_p0[22:0];
`ifdef FPMUL_STAGE3_FLAGS_EN
        r_inexact_p1 <= w_guard_p0 | w_sticky_p0;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1 -> p2: special-case selection and exponent range packing
  // ---------------------------------------------------------------------------
  logic [31:0] w_fpz_p1;
  assign w_fpz_p1 = f_final(r_nan_p1, r_inf_p1, r_zero_p1, r_sign_p1,
                            r_exp_p1, r_mant_p1);

`ifdef FPMUL_STAGE3_FLAGS_EN
  logic       w_special_p1;
  logic [2:0] w_flags_p1;
  logic [2:0] r_flags_p2;
  assign w_special_p1 = r_nan_p1 | r_inf_p1 | r_zero_p1;
  assign w_flags_p1   = w_special_p1 ? 3'b000 :
                        {(r_exp_p1 >= 10'sd255), (r_exp_p1 <= 10'sd0), r_inexact_p1};
`endif

  logic [31:0] r_fpz_p2;
  logic        r_vld_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fpz_p2   <= '0;
      r_vld_p2   <= 1'b0;
`ifdef FPMUL_STAGE3_FLAGS_EN
      r_flags_p2 <= '0;
`endif
    end else begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_fpz_p2   <= w_fpz_p1;
`ifdef FPMUL_STAGE3_FLAGS_EN
        r_flags_p2 <= w_flags_p1;
`endif
      end
    end
  end

  assign FP_Z      = r_fpz_p2;
  assign valid_out = r_vld_p2;
`ifdef FPMUL_STAGE3_FLAGS_EN
  assign FLAGS     = r_flags_p2;
`endif

endmodule

// File: tb/tb_fpmul_stage3_pack.sv
// -----------------------------------------------------------------------------
// tb_fpmul_stage3_pack
//
// Directed testbench for fpmul_stage3_pack. Expected results are worked out by
// hand from the IEEE-754 packing rules. It also checks FLAGS when
// FPMUL_STAGE3_FLAGS_EN is defined.
// -----------------------------------------------------------------------------
module tb_fpmul_stage3_pack;

  logic        clk;
  logic        rst_n;
  logic        valid_stage2;
  logic [7:0]  EXP_in;
  logic        EXP_pos_stage2;
  logic        EXP_neg_stage2;
  logic [27:0] SIG_in;
  logic        SIGN_out_stage2;
  logic        isINF_stage2;
  logic        isNaN_stage2;
  logic        isZ_tab_stage2;
  logic [31:0] FP_Z;
  logic        valid_out;
`ifdef FPMUL_STAGE3_FLAGS_EN
  logic [2:0]  FLAGS;
`endif

  int n_total = 0;
  int n_pass  = 0;

  fpmul_stage3_pack dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .valid_stage2    (valid_stage2),
    .EXP_in          (EXP_in),
    .EXP_pos_stage2  (EXP_pos_stage2),
    .EXP_neg_stage2  (EXP_neg_stage2),
    .SIG_in          (SIG_in),
    .SIGN_out_stage2 (SIGN_out_stage2),
    .isINF_stage2    (isINF_stage2),
    .isNaN_stage2    (isNaN_stage2),
    .isZ_tab_stage2  (isZ_tab_stage2),
    .FP_Z            (FP_Z),
    .valid_out       (valid_out)
`ifdef FPMUL_STAGE3_FLAGS_EN
    ,
    .FLAGS           (FLAGS)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
  endtask

  task automatic set_in(input logic [7:0] e, input logic p, input logic n,
                        input logic [27:0] s, input logic sg, input logic inf,
                        input logic nan, input logic z);
    EXP_in          = e;
    EXP_pos_stage2  = p;
    EXP_neg_stage2  = n;
    SIG_in          = s;
    SIGN_out_stage2 = sg;
    isINF_stage2    = inf;
    isNaN_stage2    = nan;
    isZ_tab_stage2  = z;
  endtask

  // One isolated transaction. The task checks that the result is not ready
  // after 1 edge, is ready after 2 edges, and that FP_Z holds once valid drops.
  task automatic run_vec(input string tag, input logic [7:0] e, input logic p,
                         input logic n, input logic [27:0] s, input logic sg,
                         input logic inf, input logic nan, input logic z,
                         input logic [31:0] exp_z, input logic [2:0] exp_f);
    string t;
    t = $sformatf("%s[f=%03b]", tag, exp_f);
    set_in(e, p, n, s, sg, inf, nan, z);
    valid_stage2 = 1'b1;
    @(posedge clk); #1;
    valid_stage2 = 1'b0;
    set_in(8'h00, 1'b0, 1'b0, 28'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({t, "_lat1"}, {31'd0, valid_out}, 32'd0);
    @(posedge clk); #1;
    chk({t, "_vld"}, {31'd0, valid_out}, 32'd1);
    chk({t, "_z"}, FP_Z, exp_z);
`ifdef FPMUL_STAGE3_FLAGS_EN
    chk({t, "_flags"}, {29'd0, FLAGS}, {29'd0, exp_f});
`endif
    @(posedge clk); #1;
    chk({t, "_drop"}, {31'd0, valid_out}, 32'd0);
    chk({t, "_hold"}, FP_Z, exp_z);
  endtask

  initial begin
    rst_n        = 1'b0;
    valid_stage2 = 1'b0;
    set_in(8'h00, 1'b0, 1'b0, 28'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_z", FP_Z, 32'h0);
    chk("rst_vld", {31'd0, valid_out}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Normal, normal boundary, and rounding cases
    run_vec("basic",   8'h7F, 0, 0, 28'h9000000, 0, 0, 0, 0, 32'h40100000, 3'b000);
    run_vec("ovf",     8'h10, 1, 0, 28'h4000000, 0, 0, 0, 0, 32'h7F800000, 3'b100);
    run_vec("unf",     8'hF0, 0, 1, 28'h4000000, 1, 0, 0, 0, 32'h80000000, 3'b010);
    run_vec("rcarry",  8'h7F, 0, 0, 28'h7FFFFFC, 0, 0, 0, 0, 32'h40000000, 3'b001);
    run_vec("tieeven", 8'h7F, 0, 0, 28'h4000004, 0, 0, 0, 0, 32'h3F800000, 3'b001);
    run_vec("tieodd",  8'h7F, 0, 0, 28'h400000C, 0, 0, 0, 0, 32'h3F800002, 3'b001);
    run_vec("sticky",  8'h7F, 0, 0, 28'h4000006, 0, 0, 0, 0, 32'h3F800001, 3'b001);
    run_vec("b27grd",  8'h7F, 0, 0, 28'h8000008, 0, 0, 0, 0, 32'h40000000, 3'b001);
    run_vec("posnoext",8'h80, 1, 0, 28'h4000000, 0, 0, 0, 0, 32'h40000000, 3'b000);
    run_vec("e254",    8'hFE, 0, 0, 28'h4000000, 0, 0, 0, 0, 32'h7F000000, 3'b000);
    run_vec("e255",    8'hFE, 0, 0, 28'h8000000, 1, 0, 0, 0, 32'hFF800000, 3'b100);
    run_vec("rndovf",  8'hFE, 0, 0, 28'h7FFFFFC, 0, 0, 0, 0, 32'h7F800000, 3'b101);
    run_vec("e1",      8'h01, 0, 0, 28'h4000000, 0, 0, 0, 0, 32'h00800000, 3'b000);
    run_vec("e0",      8'h00, 0, 0, 28'h4000000, 0, 0, 0, 0, 32'h00000000, 3'b010);
    // Special cases and their priority
    run_vec("naninf",  8'h7F, 0, 0, 28'h9000000, 1, 1, 1, 0, 32'h7FC00000, 3'b000);
    run_vec("inf",     8'h7F, 0, 0, 28'h9000000, 1, 1, 0, 0, 32'hFF800000, 3'b000);
    run_vec("zero",    8'h7F, 0, 0, 28'h9000000, 1, 0, 0, 1, 32'h80000000, 3'b000);
    run_vec("infz",    8'h7F, 0, 0, 28'h9000000, 0, 1, 0, 1, 32'h7F800000, 3'b000);

    // Four back-to-back valid cycles, with reset pulsed after the second
    set_in(8'h7F, 0, 0, 28'h9000000, 0, 0, 0, 0);
    valid_stage2 = 1'b1;
    @(posedge clk); #1;
    set_in(8'h80, 0, 0, 28'h4000000, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("b2b_vld1", {31'd0, valid_out}, 32'd1);
    chk("b2b_z1", FP_Z, 32'h40100000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_z", FP_Z, 32'h0);
    chk("arst_vld", {31'd0, valid_out}, 32'd0);
    set_in(8'h7F, 0, 0, 28'h4000004, 0, 0, 0, 0);
    @(posedge clk); #1;
    set_in(8'hFE, 0, 0, 28'h4000000, 0, 0, 0, 0);
    @(posedge clk); #1;
    valid_stage2 = 1'b0;
    set_in(8'h00, 0, 0, 28'h0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst_vld%0d", i), {31'd0, valid_out}, 32'd0);
      chk($sformatf("post_rst_z%0d", i), FP_Z, 32'h0);
    end

    // The block recovers after reset
    run_vec("recover", 8'h7F, 0, 0, 28'h9000000, 0, 0, 0, 0, 32'h40100000, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fpmul_stage3_pack.md
FPMUL_STAGE3_PACK -- requirements
Module: fpmul_stage3_pack

Interface
REQ-001 SHALL provide: clk  in  1  rising-edge clock; the block's only clock.
REQ-002 SHALL provide: rst_n  in  1  reset; asynchronous assert, active-low.
REQ-003 SHALL provide: valid_stage2  in  1  stage-2 outputs valid this cycle.
REQ-004 SHALL provide: EXP_in  in  8  biased exponent sum (A+B-127 mod 256).
REQ-005 SHALL provide: EXP_pos_stage2  in  1  both operand exponents >=128 (overflow possible).
REQ-006 SHALL provide: EXP_neg_stage2  in  1  both operand exponents <127 (underflow possible).
REQ-007 SHALL provide: SIG_in  in  28  product bits [47:20]; leading one at bit 27 or 26.
REQ-008 SHALL provide: SIGN_out_stage2, isINF_stage2, isNaN_stage2, isZ_tab_stage2  in  1 each  sign and special-case flags.
REQ-009 SHALL provide: FP_Z  out  32  packed IEEE-754 single result.
REQ-010 SHALL provide: valid_out  out  1  FP_Z updated this cycle.

Function
REQ-011 SHALL be two register stages: stage A (normalize/round) captured at edge k, output registers at edge k+1; latency 2 edges, throughput 1/cycle, no backpressure.
REQ-012 Stage A and output registers SHALL load only when their incoming valid is 1; otherwise hold; valid bits always advance.
REQ-013 Extended exponent E (10-bit signed): EXP_pos=1 & EXP_in[7]=0 -> 256+EXP_in; EXP_neg=1 & EXP_in[7]=1 -> EXP_in-256; else EXP_in.
REQ-014 SIG_in[27]=1: mant=SIG_in[26:4], guard=SIG_in[3], sticky=OR(SIG_in[2:0]), E+=1; else mant=SIG_in[25:3], guard=SIG_in[2], sticky=OR(SIG_in[1:0]).
REQ-015 Rounding SHALL be nearest-even: increment mant when guard & (sticky | mant[0]); mant carry-out -> mant=0, E+=1.
REQ-016 Final E>=255 -> {sign,8'hFF,23'h0}; final E<=0 -> {sign,31'h0} (flush, no subnormals); else {sign,E[7:0],mant}.
REQ-017 Special priority: isNaN -> 32'h7FC00000 (sign ignored); else isINF -> {sign,8'hFF,23'h0}; else isZ_tab -> {sign,31'h0}; else REQ-016.
REQ-018 Special flags SHALL be carried through stage A with the data, never re-sampled.

Reset
REQ-019 rst_n low SHALL asynchronously clear FP_Z to 0, valid_out to 0, all stage-A registers and valid bits to 0.
REQ-020 Reset mid-operation SHALL discard in-flight results; first valid_out after release only from valid_stage2 sampled after release.

Configuration
REQ-021 Macro FPMUL_STAGE3_FLAGS_EN defined: add output FLAGS[2:0] = {overflow, underflow, inexact}, registered with FP_Z, cleared by reset, all 0 for special-case results; inexact = guard|sticky.
REQ-022 Macro undefined: FLAGS port and its logic SHALL be absent; FP_Z/valid_out behaviour identical.

Verification
REQ-023 EXP_in=8'h7F, SIG_in=28'h9000000, sign 0, valid 1 -> FP_Z=32'h40100000, valid_out 1 exactly 2 edges later.
REQ-024 EXP_in=8'h10, EXP_pos=1, SIG_in=28'h4000000 -> FP_Z=32'h7F800000 (FLAGS=3'b100 when enabled).
REQ-025 EXP_in=8'hF0, EXP_neg=1, sign 1 -> FP_Z=32'h80000000 (FLAGS=3'b010 when enabled).
REQ-026 EXP_in=8'h7F, SIG_in=28'h7FFFFFC -> round carry, FP_Z=32'h40000000; SIG_in=28'h4000004 -> tie to even, FP_Z=32'h3F800000.
REQ-027 isNaN=1 and isINF=1, sign 1 -> FP_Z=32'h7FC00000; isINF only, sign 1 -> 32'hFF800000.
REQ-028 Back-to-back valid for 4 cycles, rst_n pulsed low after 2nd -> FP_Z=0, valid_out=0 immediately; no stale result emitted after release.
